// File: rtl/cw305_reg_top_pkg.sv
// Shared constants for the CW305 register-mapped target: register map,
// identify value, field widths and core state encoding.
package cw305_reg_top_pkg;

    localparam int DATA_WIDTH  = 128;
    localparam int BLOCK_WIDTH = 2;
    localparam int REG_WIDTH   = 6;
    localparam int NUM_BYTES   = DATA_WIDTH / 8;

    localparam logic [REG_WIDTH-1:0] REG_IDENTIFY  = 6'h04;
    localparam logic [REG_WIDTH-1:0] REG_GO        = 6'h05;
    localparam logic [REG_WIDTH-1:0] REG_TEXTIN    = 6'h06;
    localparam logic [REG_WIDTH-1:0] REG_CIPHEROUT = 6'h09;
    localparam logic [REG_WIDTH-1:0] REG_KEY       = 6'h0A;

    localparam logic [7:0] IDENTIFY_VALUE = 8'h2E;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } core_state_e;

endpackage

// File: rtl/cw305_xor_core.sv
// Fixed-latency stand-in crypto core: latches operands on start, then
// publishes text XOR key exactly pCORE_CYCLES cycles later.
module cw305_xor_core
    import cw305_reg_top_pkg::*;
#(
    parameter int pCORE_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_text,
    input  logic [DATA_WIDTH-1:0] i_key,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int CW = $clog2(pCORE_CYCLES + 1);

    core_state_e           r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_text;
    logic [DATA_WIDTH-1:0] r_key;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_busy;
    logic                  r_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_text   <= '0;
            r_key    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_BUSY;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_text  <= i_text;
                        r_key   <= i_key;
                    end
                end
                ST_BUSY: begin
                    // Counter value k is seen at edge k+1; the last busy edge is pCORE_CYCLES.
                    if (r_cnt == CW'(pCORE_CYCLES - 1)) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_result <= r_text ^ r_key;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_valid  = r_valid;
    assign o_result = r_result;

endmodule

// File: rtl/cw305_reg_top.sv
// CW305 target top: byte-wide USB bus decode, TEXTIN/KEY register file,
// registered read path with tristate data bus, and the XOR core.
module cw305_reg_top
    import cw305_reg_top_pkg::*;
#(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pCORE_CYCLES  = 16
) (
    input  logic                   usb_clk,
    input  logic                   reset,
    inout  wire  [7:0]             usb_data,
    input  logic [pADDR_WIDTH-1:0] usb_addr,
    input  logic                   usb_rdn,
    input  logic                   usb_wrn,
    input  logic                   usb_cen,
    input  logic                   usb_trigger,
    output logic                   led1,
    output logic                   led2,
    output logic                   led3,
    output logic                   tio_trigger
);

    logic [pBYTECNT_SIZE-1:0] w_sub;
    logic [REG_WIDTH-1:0]     w_reg;
    logic [BLOCK_WIDTH-1:0]   w_blk;
    logic [3:0]               w_byte;
    logic [6:0]               w_bit;
    logic                     w_sel;
    logic                     w_wr;
    logic                     w_rd_drive;
    logic                     w_start;
    logic                     w_busy;
    logic                     w_valid;
    logic [DATA_WIDTH-1:0]    w_result;
    logic [7:0]               w_rd_byte;
    logic                     w_unused;

    logic [DATA_WIDTH-1:0]    r_textin;
    logic [DATA_WIDTH-1:0]    r_key;
    logic [7:0]               r_rd_data;

    assign w_sub  = usb_addr[pBYTECNT_SIZE-1:0];
    assign w_reg  = usb_addr[pBYTECNT_SIZE +: REG_WIDTH];
    assign w_blk  = usb_addr[pBYTECNT_SIZE + REG_WIDTH +: BLOCK_WIDTH];
    assign w_byte = w_sub[3:0];
    assign w_bit  = {w_byte, 3'b000};
    assign w_sel  = (w_blk == '0) && (int'(w_sub) < NUM_BYTES);

    assign w_wr       = !usb_cen && !usb_wrn;
    assign w_rd_drive = !usb_cen && !usb_rdn && usb_wrn;
    assign w_start    = w_wr && w_sel && (w_reg == REG_GO) && usb_data[0];

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            r_textin <= '0;
            r_key    <= '0;
        end else if (w_wr && w_sel) begin
            case (w_reg)
                REG_TEXTIN: r_textin[w_bit +: 8] <= usb_data;
                REG_KEY:    r_key[w_bit +: 8]    <= usb_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_byte = '0;
        if (w_sel) begin
            case (w_reg)
                REG_IDENTIFY:  w_rd_byte = IDENTIFY_VALUE;
                REG_GO:        w_rd_byte = {7'b0, w_busy};
                REG_TEXTIN:    w_rd_byte = r_textin[w_bit +: 8];
                REG_CIPHEROUT: w_rd_byte = w_result[w_bit +: 8];
                REG_KEY:       w_rd_byte = r_key[w_bit +: 8];
                default:       w_rd_byte = '0;
            endcase
        end
    end

    // Address is stable across a strobe, so sampling every cycle keeps the read byte current.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_byte;
        end
    end

    assign usb_data = w_rd_drive ? r_rd_data : 8'bz;

    cw305_xor_core #(
        .pCORE_CYCLES(pCORE_CYCLES)
    ) u_core (
        .i_clk   (usb_clk),
        .i_rst   (reset),
        .i_start (w_start),
        .i_text  (r_textin),
        .i_key   (r_key),
        .o_busy  (w_busy),
        .o_valid (w_valid),
        .o_result(w_result)
    );

    assign led1        = w_busy;
    assign led2        = reset;
    assign led3        = w_valid;
    assign tio_trigger = w_busy;

    assign w_unused = ^{usb_trigger, usb_addr};

endmodule

// File: tb/tb_cw305_reg_top.sv
// Directed bench for cw305_reg_top: bus reads/writes, XOR result, trigger
// width, busy-time writes, mid-run reset and address filtering.
module tb_cw305_reg_top;

    logic        usb_clk;
    logic        reset;
    logic [20:0] usb_addr;
    logic        usb_rdn;
    logic        usb_wrn;
    logic        usb_cen;
    logic        usb_trigger;
    logic        led1;
    logic        led2;
    logic        led3;
    logic        tio_trigger;
    wire  [7:0]  w_data;
    logic [7:0]  tb_data;
    logic        tb_drive;

    int checks;
    int errors;
    int trig_cycles;
    int trig_rises;
    logic trig_prev;

    assign w_data = tb_drive ? tb_data : 8'bz;
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (w_data[g]);
    end

    cw305_reg_top #(
        .pADDR_WIDTH  (21),
        .pBYTECNT_SIZE(7),
        .pCORE_CYCLES (16)
    ) dut (
        .usb_clk    (usb_clk),
        .reset      (reset),
        .usb_data   (w_data),
        .usb_addr   (usb_addr),
        .usb_rdn    (usb_rdn),
        .usb_wrn    (usb_wrn),
        .usb_cen    (usb_cen),
        .usb_trigger(usb_trigger),
        .led1       (led1),
        .led2       (led2),
        .led3       (led3),
        .tio_trigger(tio_trigger)
    );

    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    initial begin
        trig_cycles = 0;
        trig_rises  = 0;
        trig_prev   = 1'b0;
    end
    always @(negedge usb_clk) begin
        if (tio_trigger) trig_cycles++;
        if (tio_trigger && !trig_prev) trig_rises++;
        trig_prev = tio_trigger;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] mk_addr(input logic [1:0] blk, input logic [5:0] rg, input logic [6:0] sub);
        return {6'b0, blk, rg, sub};
    endfunction

    task automatic bus_write(input logic [1:0] blk, input logic [5:0] rg, input logic [6:0] sub, input logic [7:0] d);
        @(negedge usb_clk);
        usb_addr = mk_addr(blk, rg, sub);
        tb_data  = d;
        tb_drive = 1'b1;
        usb_cen  = 1'b0;
        usb_wrn  = 1'b0;
        @(negedge usb_clk);
        usb_wrn  = 1'b1;
        usb_cen  = 1'b1;
        tb_drive = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] blk, input logic [5:0] rg, input logic [6:0] sub, output logic [7:0] d);
        @(negedge usb_clk);
        usb_addr = mk_addr(blk, rg, sub);
        usb_cen  = 1'b0;
        usb_rdn  = 1'b0;
        @(negedge usb_clk);
        d       = w_data;
        usb_rdn = 1'b1;
        usb_cen = 1'b1;
    endtask

    task automatic write128(input logic [5:0] rg, input logic [127:0] v);
        for (int i = 0; i < 16; i++) bus_write(2'd0, rg, 7'(i), v[8*i +: 8]);
    endtask

    task automatic read128(input logic [5:0] rg, output logic [127:0] v);
        logic [7:0] b;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, rg, 7'(i), b);
            v[8*i +: 8] = b;
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (!led1) break;
            @(negedge usb_clk);
        end
        check(tag, {127'b0, led1}, 128'd0);
    endtask

    localparam logic [5:0] A_ID = 6'h04;
    localparam logic [5:0] A_GO = 6'h05;
    localparam logic [5:0] A_TX = 6'h06;
    localparam logic [5:0] A_CO = 6'h09;
    localparam logic [5:0] A_KY = 6'h0A;

    initial begin
        logic [7:0]   b;
        logic [127:0] v;
        int           snap_cyc;
        int           snap_rise;

        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        usb_addr    = '0;
        usb_rdn     = 1'b1;
        usb_wrn     = 1'b1;
        usb_cen     = 1'b1;
        usb_trigger = 1'b0;
        tb_data     = '0;
        tb_drive    = 1'b0;

        // Reset state
        repeat (3) @(negedge usb_clk);
        check("led2_in_reset", {127'b0, led2}, 128'd1);
        check("busy_in_reset", {127'b0, led1}, 128'd0);
        check("trig_in_reset", {127'b0, tio_trigger}, 128'd0);
        check("valid_in_reset", {127'b0, led3}, 128'd0);
        reset = 1'b0;
        @(negedge usb_clk);
        check("led2_after_reset", {127'b0, led2}, 128'd0);

        bus_read(2'd0, A_ID, 7'd0, b);
        check("identify", {120'b0, b}, 128'h2E);
        bus_read(2'd0, A_GO, 7'd0, b);
        check("go_idle", {120'b0, b}, 128'h00);
        read128(A_CO, v);
        check("cipher_reset", v, 128'h0);

        // Vector 1: all-ones text against mixed key
        write128(A_TX, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF);
        write128(A_KY, 128'h80000000_00000000_00000000_FFFFFFFF);
        snap_cyc  = trig_cycles;
        snap_rise = trig_rises;
        bus_write(2'd0, A_GO, 7'd0, 8'h01);
        check("busy_after_go", {127'b0, led1}, 128'd1);
        wait_idle("idle_timeout_v1");
        check("trig_width_v1", 128'(trig_cycles - snap_cyc), 128'd16);
        check("trig_pulses_v1", 128'(trig_rises - snap_rise), 128'd1);
        bus_read(2'd0, A_GO, 7'd0, b);
        check("go_done_v1", {120'b0, b}, 128'h00);
        check("valid_v1", {127'b0, led3}, 128'd1);
        read128(A_CO, v);
        check("cipher_v1", v, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_00000000);

        // Vector 2: small operands, readback of written registers
        write128(A_TX, 128'h1234);
        write128(A_KY, 128'h0005);
        read128(A_TX, v);
        check("textin_readback", v, 128'h1234);
        read128(A_KY, v);
        check("key_readback", v, 128'h0005);
        bus_write(2'd0, A_GO, 7'd0, 8'h00);
        check("go_bit0_zero", {127'b0, led1}, 128'd0);
        bus_write(2'd0, A_GO, 7'd0, 8'h01);
        check("valid_cleared_on_go", {127'b0, led3}, 128'd0);
        wait_idle("idle_timeout_v2");
        read128(A_CO, v);
        check("cipher_v2", v, 128'h1231);

        // Vector 3: operand write and second GO while busy
        snap_cyc  = trig_cycles;
        snap_rise = trig_rises;
        bus_write(2'd0, A_GO, 7'd0, 8'h01);
        bus_write(2'd0, A_KY, 7'd0, 8'h00);
        bus_write(2'd0, A_GO, 7'd0, 8'h01);
        wait_idle("idle_timeout_v3");
        repeat (3) @(negedge usb_clk);
        check("trig_width_v3", 128'(trig_cycles - snap_cyc), 128'd16);
        check("trig_pulses_v3", 128'(trig_rises - snap_rise), 128'd1);
        read128(A_CO, v);
        check("cipher_v3", v, 128'h1231);
        bus_read(2'd0, A_KY, 7'd0, b);
        check("key_written_busy", {120'b0, b}, 128'h00);

        // Vector 4: reset at cycle 8 of a computation
        bus_write(2'd0, A_GO, 7'd0, 8'h01);
        repeat (7) @(negedge usb_clk);
        check("busy_before_abort", {127'b0, led1}, 128'd1);
        reset = 1'b1;
        @(negedge usb_clk);
        check("busy_aborted", {127'b0, led1}, 128'd0);
        check("trig_aborted", {127'b0, tio_trigger}, 128'd0);
        check("led2_mid_reset", {127'b0, led2}, 128'd1);
        reset = 1'b0;
        read128(A_CO, v);
        check("cipher_after_abort", v, 128'h0);
        read128(A_TX, v);
        check("textin_after_abort", v, 128'h0);

        // Address filtering and bus release
        bus_write(2'd0, A_TX, 7'd0, 8'h11);
        bus_write(2'd1, A_TX, 7'd0, 8'hAB);
        bus_write(2'd0, A_TX, 7'd20, 8'hCD);
        bus_read(2'd1, A_TX, 7'd0, b);
        check("block1_read", {120'b0, b}, 128'h00);
        bus_read(2'd1, A_ID, 7'd0, b);
        check("block1_identify", {120'b0, b}, 128'h00);
        bus_read(2'd0, A_TX, 7'd20, b);
        check("subbyte20_read", {120'b0, b}, 128'h00);
        bus_read(2'd0, 6'h07, 7'd0, b);
        check("unmapped_read", {120'b0, b}, 128'h00);
        read128(A_TX, v);
        check("textin_filtered", v, 128'h11);

        @(negedge usb_clk);
        usb_addr = mk_addr(2'd0, A_ID, 7'd0);
        usb_cen  = 1'b0;
        repeat (2) @(negedge usb_clk);
        check("bus_released_rdn_high", {120'b0, w_data}, 128'hFF);
        usb_cen = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cw305_reg_top.md
# cw305_reg_top

Register-mapped target top for the CW305 power-analysis board. Exposes a byte-wide, active-low-strobed USB parallel bus through which the host loads a 128-bit text and a 128-bit key, starts a fixed-latency crypto core, polls busy and reads the 128-bit result. Drives a trigger pin high while the core runs so scope captures align with the computation.

## Interface
Parameters:
- pADDR_WIDTH, 21: USB address width.
- pBYTECNT_SIZE, 7: subbyte field width (low address bits).
- pCORE_CYCLES, 16: core latency in usb_clk cycles.

Ports:
- usb_clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- usb_data  inout  8  bidirectional data; driven only during reads.
- usb_addr  in  pADDR_WIDTH  {block[1:0], reg[5:0], subbyte[6:0]}, upper bits ignored.
- usb_rdn  in  1  read strobe, active low.
- usb_wrn  in  1  write strobe, active low.
- usb_cen  in  1  chip enable, active low.
- usb_trigger  in  1  unused; ignored.
- led1  out  1  core busy.
- led2  out  1  high when reset asserted.
- led3  out  1  result valid (set at completion, cleared on GO).
- tio_trigger  out  1  high exactly while core busy.

## Operation
- Register map (reg field, block must be 0; other blocks: writes ignored, reads 0x00): 0x04 IDENTIFY (RO, 0x2E); 0x05 GO (W: bit0=1 starts; R: bit0=busy, other bits 0); 0x06 TEXTIN (RW, 16 bytes); 0x09 CIPHEROUT (RO, 16 bytes); 0x0A KEY (RW, 16 bytes). Unmapped regs read 0x00, writes ignored.
- Byte i (subbyte 0..15) maps to bits [8i+7:8i]; subbyte ≥16 reads 0x00, writes ignored.
- Write: on any rising edge where usb_cen=0 and usb_wrn=0, store usb_data at the decoded address. Repeated captures of the same byte during one strobe are harmless.
- Read: while usb_rdn=0 and usb_cen=0, drive usb_data with the registered read byte of the addressed location; otherwise high-Z. Write takes priority if wrn and rdn both low (no drive).
- GO write with bit0=1 while idle: latch TEXTIN and KEY into core, busy=1. GO while busy: ignored. GO with bit0=0: no effect.
- Core result: CIPHEROUT = TEXTIN_latched XOR KEY_latched, written after pCORE_CYCLES cycles; busy then clears same edge.
- TEXTIN/KEY writes during busy update the registers but do not affect the running computation.
- Reset: TEXTIN, KEY, CIPHEROUT = 0; busy=0; valid=0; tio_trigger=0; usb_data high-Z; led2=1 only while reset high. Reset mid-computation aborts; CIPHEROUT stays 0.

## Timing
- Write latency: register updated at the first rising edge with cen=0 & wrn=0.
- Read data valid on usb_data no later than 1 cycle after rdn & cen fall; held while both low; address stable during strobe.
- GO capture edge = cycle 0; busy/tio_trigger high from cycle 1 through cycle pCORE_CYCLES; CIPHEROUT and busy=0 at edge pCORE_CYCLES.
- Busy poll via GO reads returning 0 guarantees CIPHEROUT is final.

## Structure
- Shared package: register address constants (IDENTIFY, GO, TEXTIN, CIPHEROUT, KEY), IDENTIFY value 0x2E, block width, data width 128.
- Sub-module cw305_xor_core: start/busy/done handshake, cycle counter, latched operands, result register. Top holds bus decode, register file, tristate.

## Test plan
- Reset then read IDENTIFY -> 0x2E; read GO -> 0x00; read CIPHEROUT all bytes -> 0x00.
- Write TEXTIN=0xFFFF..FF, KEY={0x80000000,0,0,0xFFFFFFFF}, GO=1, poll busy -> CIPHEROUT 0x7FFFFFFF_FFFFFFFF_FFFFFFFF_00000000; tio_trigger high exactly 16 cycles.
- TEXTIN=0x1234, KEY=0x0005 -> CIPHEROUT 0x...00001231; readback of TEXTIN/KEY bytes equals written.
- Start, then write KEY=0 and GO=1 during busy -> result unchanged from first operands; only one busy period.
- Assert reset at cycle 8 of computation -> busy=0, tio_trigger=0, CIPHEROUT=0.
- Access block=1 or subbyte 20 -> writes ignored, reads 0x00; usb_data high-Z when rdn=1.
